mem_lane_ctrl: RTL and testbench
================================

# mem_lane_ctrl

Byte-lane access controller that sits directly upstream of the four-lane dual-port RAM and converts one processor-side byte-addressed access into four per-lane 8-bit RAM accesses. It supports byte, halfword and word accesses at any alignment. Unaligned accesses spill into the next word address on the low lanes. The block also consumes the RAM's lane read data after the RAM read latency, then rotates and extends it into a 32-bit result. It owns one RAM port (A or B); a second instance serves the other port.

## Interface
- ADDR_W, 13, per-lane word address width; the byte address is ADDR_W+2 bits.
- LAT, 2, RAM read latency in clocks (1 + RAM output register enable); legal values 1–4.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous assert, active-low.
- req_i  in  1  access request, valid for one cycle.
- wr_i  in  1  1 = write, 0 = read; qualified by req_i.
- width_i  in  2  0 = byte, 1 = halfword, 2 = word, 3 = treated as word.
- sgn_i  in  1  read result sign-extend (1) / zero-extend (0).
- addr_i  in  ADDR_W+2  byte address.
- data_i  in  32  write data, LSB-justified.
- l3..l0_addr_o  out  ADDR_W  lane addresses to RAM.
- l3..l0_wr_o  out  1  lane write enables.
- l3..l0_o  out  8  lane write data.
- l3..l0_i  in  8  lane read data from RAM.
- rd_o  out  32  read result.
- rd_vld_o  out  1  rd_o valid strobe.

## Operation
- Access geometry:
  - off = addr_i[1:0], wa = addr_i[ADDR_W+1:2].
  - n = 1/2/4 bytes for width 0/1/2(3).
- Per lane L:
  - k = (L − off) mod 4.
  - Lane active iff k < n.
  - Lane address = wa + 1 if L < off, else wa; the sum wraps modulo 2^ADDR_W, so the top word spills to word 0.
  - Inactive lanes still drive address wa (harmless reads).
- Write: active lanes assert lN_wr_o = req_i & wr_i; lN_o = data_i byte k. Inactive lanes have wr = 0 and data = 0.
- Read: a pipeline of LAT stages carries {vld, off, width, sgn}, one request per clock with no backpressure. At stage LAT the block gathers byte k from lane (off+k) mod 4 for k < n.
- Read extension: upper bits of rd_o are filled with bit 8n−1 when sgn = 1, else 0; a word read ignores sgn.
- Writes do not enter the result path; they produce no rd_vld_o.
- No write/read forwarding. The RAM's own read-during-write mode governs same-cycle same-address behaviour. A read issued the cycle after a write returns the new data.
- Reset (rst_i low):
  - rd_o = 0, rd_vld_o = 0.
  - The pipeline valid bits clear; in-flight reads are discarded.
  - All lN_wr_o are forced 0 regardless of req_i.
  - The first request is accepted on the first rising edge after rst_i deasserts.

## Timing
- Lane address/enable/data outputs are combinational from the request inputs in cycle t; the RAM registers them at the edge ending cycle t.
- Lane read data is sampled at the end of cycle t+LAT.
- rd_o and rd_vld_o are registered and are valid during cycle t+LAT+1 (default: 3 clocks after the request edge).
- rd_vld_o is a single-cycle pulse per read. Back-to-back reads give consecutive pulses in issue order.
- rd_o holds its last value when rd_vld_o is low.
- A read and a write in consecutive cycles are independent; the write takes no slot in the result pipeline.

## Structure
- Package mem_lane_pkg holds:
  - typedef enum for width (BYTE, HALF, WORD);
  - LANES = 4 and the lane byte width 8;
  - a function computing the active-lane mask from (off, width).
- Sub-module mem_lane_rot holds the combinational read gather, rotate and extend. It takes lane data, off, width and sgn, and returns 32 bits; the parent registers its output.
- The parent holds the lane address/enable generation, the LAT-deep control shift pipeline and the output register.

## Test plan
- Aligned word write at addr 0x0010, data 0x11223344, then a read → lanes 0..3 written at word 4 with 0x44, 0x33, 0x22, 0x11; rd_o = 0x11223344 three clocks after the read request.
- Unaligned word write at addr 0x0013, data 0xAABBCCDD → lane 3 at word 4 gets 0xDD; lanes 0, 1, 2 at word 5 get 0xCC, 0xBB, 0xAA; a read back returns 0xAABBCCDD.
- Halfword read at addr 0x0006 holding bytes {0x80, 0xFE} (low byte first) → sgn = 1 gives 0xFFFFFE80; sgn = 0 gives 0x0000FE80.
- Wrap: word write at the top byte address (all ones) → lane 3 at word 2^ADDR_W−1; lanes 0–2 at word 0; no other lanes written.
- Pipelining: reads issued on 5 consecutive clocks → 5 consecutive rd_vld_o pulses with matching data in order. Interleaved writes produce no pulses.
- Reset mid-flight: assert rst_i one cycle after a read request → no rd_vld_o ever appears for that request; rd_o = 0; lN_wr_o = 0 while in reset even with req_i = wr_i = 1.

Source files
------------

// File: rtl/mem_lane_pkg.sv
// Shared types and helpers for the byte-lane access controller.
// Holds the access-width encoding, the lane geometry and the active-lane mask.
package mem_lane_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } width_e;

  // Encoding 3 is treated as a word access.
  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      BYTE:    width_bytes = 3'd1;
      HALF:    width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] off,
                                                 input logic [1:0] width);
    logic [2:0] n;
    logic [1:0] k;
    n = width_bytes(width);
    lane_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      k = 2'(l) - off;
      lane_mask[l] = ({1'b0, k} < n);
    end
  endfunction

endpackage

// File: rtl/mem_lane_rot.sv
// Read-side gather: picks result byte k from lane (off+k) mod 4, then
// zero- or sign-extends byte and halfword results to 32 bits.
module mem_lane_rot
  import mem_lane_pkg::*;
(
  input  logic [LANES-1:0][LANE_W-1:0] lane_i,
  input  logic [1:0]                   off_i,
  input  logic [1:0]                   width_i,
  input  logic                         sgn_i,
  output logic [31:0]                  rd_o
);

  logic [LANES-1:0][LANE_W-1:0] gath;

  always_comb begin
    gath = '0;
    for (int k = 0; k < LANES; k++) begin
      gath[k] = lane_i[2'(k) + off_i];
    end
    case (width_i)
      BYTE:    rd_o = {{24{sgn_i & gath[0][7]}}, gath[0]};
      HALF:    rd_o = {{16{sgn_i & gath[1][7]}}, gath[1], gath[0]};
      default: rd_o = gath;
    endcase
  end

endmodule

// File: rtl/mem_lane_ctrl.sv
// Splits one byte-addressed access into four per-lane RAM accesses and
// reassembles the lane read data, LAT clocks later, into a 32-bit result.
module mem_lane_ctrl
  import mem_lane_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int LAT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        width_i,
  input  logic              sgn_i,
  input  logic [ADDR_W+1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic [ADDR_W-1:0] l3_addr_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [ADDR_W-1:0] l1_addr_o,
  output logic [ADDR_W-1:0] l0_addr_o,
  output logic              l3_wr_o,
  output logic              l2_wr_o,
  output logic              l1_wr_o,
  output logic              l0_wr_o,
  output logic [7:0]        l3_o,
  output logic [7:0]        l2_o,
  output logic [7:0]        l1_o,
  output logic [7:0]        l0_o,
  input  logic [7:0]        l3_i,
  input  logic [7:0]        l2_i,
  input  logic [7:0]        l1_i,
  input  logic [7:0]        l0_i,
  output logic [31:0]       rd_o,
  output logic              rd_vld_o
);

  logic [1:0]                   off;
  logic [ADDR_W-1:0]            wa;
  logic [ADDR_W-1:0]            wa_nxt;
  logic [LANES-1:0]             act;
  logic [LANES-1:0][ADDR_W-1:0] l_addr;
  logic [LANES-1:0]             l_wr;
  logic [LANES-1:0][LANE_W-1:0] l_wd;

  assign off    = addr_i[1:0];
  assign wa     = addr_i[ADDR_W+1:2];
  assign wa_nxt = wa + ADDR_W'(1);
  assign act    = lane_mask(off, width_i);

  // Lanes below the offset hold the spill bytes of the next word; reset gates writes.
  always_comb begin
    l_addr = '0;
    l_wr   = '0;
    l_wd   = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [1:0] k;
      k = 2'(l) - off;
      l_addr[l] = (act[l] && (2'(l) < off)) ? wa_nxt : wa;
      l_wr[l]   = act[l] & req_i & wr_i & rst_i;
      l_wd[l]   = act[l] ? data_i[{k, 3'b000} +: 8] : 8'h00;
    end
  end

  assign {l3_addr_o, l2_addr_o, l1_addr_o, l0_addr_o} = l_addr;
  assign {l3_wr_o, l2_wr_o, l1_wr_o, l0_wr_o}         = l_wr;
  assign {l3_o, l2_o, l1_o, l0_o}                     = l_wd;

  // Stages 1..LAT: read control tracks the RAM latency
  logic       vld_p   [1:LAT];
  logic [1:0] off_p   [1:LAT];
  logic [1:0] width_p [1:LAT];
  logic       sgn_p   [1:LAT];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 1; s <= LAT; s++) vld_p[s] <= 1'b0;
    end else begin
      vld_p[1] <= req_i & ~wr_i;
      for (int s = 2; s <= LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    off_p[1]   <= off;
    width_p[1] <= width_i;
    sgn_p[1]   <= sgn_i;
    for (int s = 2; s <= LAT; s++) begin
      off_p[s]   <= off_p[s-1];
      width_p[s] <= width_p[s-1];
      sgn_p[s]   <= sgn_p[s-1];
    end
  end

  logic [31:0] rot_rd;

  mem_lane_rot u_rot (
    .lane_i  ({l3_i, l2_i, l1_i, l0_i}),
    .off_i   (off_p[LAT]),
    .width_i (width_p[LAT]),
    .sgn_i   (sgn_p[LAT]),
    .rd_o    (rot_rd)
  );

  // Output stage: result register holds between strobes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_o     <= '0;
      rd_vld_o <= 1'b0;
    end else begin
      rd_vld_o <= vld_p[LAT];
      if (vld_p[LAT]) rd_o <= rot_rd;
    end
  end

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Bench for mem_lane_ctrl: a lane RAM with two-clock read latency, plus a flat
// byte-addressed reference memory that predicts lane traffic and read results.
module tb_mem_lane_ctrl;

  localparam int AW   = 13;
  localparam int LAT  = 2;
  localparam int BA_W = AW + 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i, wr_i, sgn_i;
  logic [1:0]    width_i;
  logic [BA_W-1:0] addr_i;
  logic [31:0]   data_i;
  logic [AW-1:0] l3_addr_o, l2_addr_o, l1_addr_o, l0_addr_o;
  logic          l3_wr_o, l2_wr_o, l1_wr_o, l0_wr_o;
  logic [7:0]    l3_o, l2_o, l1_o, l0_o;
  logic [7:0]    l3_i, l2_i, l1_i, l0_i;
  logic [31:0]   rd_o;
  logic          rd_vld_o;

  always #5 clk = ~clk;

  mem_lane_ctrl #(.ADDR_W(AW), .LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wr_i(wr_i), .width_i(width_i),
    .sgn_i(sgn_i), .addr_i(addr_i), .data_i(data_i),
    .l3_addr_o(l3_addr_o), .l2_addr_o(l2_addr_o), .l1_addr_o(l1_addr_o), .l0_addr_o(l0_addr_o),
    .l3_wr_o(l3_wr_o), .l2_wr_o(l2_wr_o), .l1_wr_o(l1_wr_o), .l0_wr_o(l0_wr_o),
    .l3_o(l3_o), .l2_o(l2_o), .l1_o(l1_o), .l0_o(l0_o),
    .l3_i(l3_i), .l2_i(l2_i), .l1_i(l1_i), .l0_i(l0_i),
    .rd_o(rd_o), .rd_vld_o(rd_vld_o)
  );

  logic [AW-1:0] la [4];
  logic          lw [4];
  logic [7:0]    ld [4];
  logic [7:0]    lq [4];
  assign la[0] = l0_addr_o; assign la[1] = l1_addr_o; assign la[2] = l2_addr_o; assign la[3] = l3_addr_o;
  assign lw[0] = l0_wr_o;   assign lw[1] = l1_wr_o;   assign lw[2] = l2_wr_o;   assign lw[3] = l3_wr_o;
  assign ld[0] = l0_o;      assign ld[1] = l1_o;      assign ld[2] = l2_o;      assign ld[3] = l3_o;
  assign l0_i = lq[0]; assign l1_i = lq[1]; assign l2_i = lq[2]; assign l3_i = lq[3];

  // Lane RAM: address registered at the edge, output register adds a second clock.
  logic [7:0] ram [4][1<<AW];
  logic [7:0] r1  [4];
  bit         ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int l = 0; l < 4; l++)
        for (int w = 0; w < (1<<AW); w++) ram[l][w] <= 8'h00;
      ram_init <= 1'b1;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (lw[l]) ram[l][la[l]] <= ld[l];
        r1[l] <= ram[l][la[l]];
        lq[l] <= r1[l];
      end
    end
  end

  typedef struct { int due; logic [31:0] val; } exp_t;
  exp_t        q[$];
  logic [7:0]  fmem [1<<BA_W];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'h0;

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [BA_W-1:0] a, input logic [1:0] w, input logic s);
    int n = nbytes(w);
    logic [31:0] v = '0;
    logic [BA_W-1:0] b;
    for (int i = 0; i < n; i++) begin
      b = a + BA_W'(i);
      v[8*i +: 8] = fmem[b];
    end
    if (s && n < 4 && v[8*n-1])
      for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every byte i of the access lands at flat byte address a+i.
  task automatic check_lanes(input logic w, input logic [1:0] wd, input logic [BA_W-1:0] a, input logic [31:0] d);
    int n = nbytes(wd);
    logic [BA_W-1:0] b;
    logic [AW-1:0] ea;
    logic ew;
    logic [7:0] ed;
    for (int l = 0; l < 4; l++) begin
      ea = a[BA_W-1:2]; ew = 1'b0; ed = 8'h00;
      for (int i = 0; i < n; i++) begin
        b = a + BA_W'(i);
        if (int'(b[1:0]) == l) begin
          ea = b[BA_W-1:2]; ew = w; ed = d[8*i +: 8];
        end
      end
      chk($sformatf("lane%0d @%h", l, a), {la[l], lw[l], ld[l]}, {ea, ew, ed});
    end
  endtask

  task automatic check_out();
    if (q.size() != 0 && q[0].due == cyc) begin
      chk($sformatf("rd_vld c%0d", cyc), rd_vld_o, 1);
      chk($sformatf("rd_o c%0d", cyc), rd_o, q[0].val);
      last_rd = q[0].val;
      void'(q.pop_front());
    end else begin
      chk($sformatf("rd_vld idle c%0d", cyc), rd_vld_o, 0);
      chk($sformatf("rd_o hold c%0d", cyc), rd_o, last_rd);
    end
  endtask

  // One clock: drive at the falling edge, check lanes, advance, check outputs.
  task automatic op(input logic r, input logic w, input logic [1:0] wd, input logic s,
                    input logic [BA_W-1:0] a, input logic [31:0] d,
                    input bit directed, input logic [31:0] dexp);
    logic [BA_W-1:0] b;
    req_i = r; wr_i = w; width_i = wd; sgn_i = s; addr_i = a; data_i = d;
    #1;
    if (r) check_lanes(w, wd, a, d);
    else chk("idle no write", {lw[3], lw[2], lw[1], lw[0]}, 0);
    if (r && w)
      for (int i = 0; i < nbytes(wd); i++) begin
        b = a + BA_W'(i);
        fmem[b] = d[8*i +: 8];
      end
    if (r && !w) q.push_back('{cyc + LAT + 1, directed ? dexp : model_read(a, wd, s)});
    @(posedge clk);
    cyc++;
    @(negedge clk);
    req_i = 1'b0; wr_i = 1'b0;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [BA_W-1:0] a, input logic [1:0] wd, input logic s);
    op(1'b1, 1'b0, wd, s, a, $urandom, 1'b0, '0);
  endtask

  task automatic wrt(input logic [BA_W-1:0] a, input logic [1:0] wd, input logic [31:0] d);
    op(1'b1, 1'b1, wd, 1'b0, a, d, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1<<BA_W); i++) fmem[i] = 8'h00;
    rst_i = 1'b0; req_i = 1'b0; wr_i = 1'b0; width_i = 2'd0; sgn_i = 1'b0;
    addr_i = '0; data_i = '0;
    repeat (3) @(negedge clk);
    req_i = 1'b1; wr_i = 1'b1; width_i = 2'd2; addr_i = 15'h0010; data_i = 32'hDEADBEEF;
    #1;
    chk("reset rd_o", rd_o, 0);
    chk("reset rd_vld", rd_vld_o, 0);
    chk("reset lane wr", {lw[3], lw[2], lw[1], lw[0]}, 0);
    req_i = 1'b0; wr_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;

    // Aligned word write and read-back
    wrt(15'h0010, 2'd2, 32'h11223344);
    op(1'b1, 1'b0, 2'd2, 1'b0, 15'h0010, 32'h0, 1'b1, 32'h11223344);
    idle(3);
    // Unaligned word spills into the next word on the low lanes
    wrt(15'h0013, 2'd2, 32'hAABBCCDD);
    op(1'b1, 1'b0, 2'd2, 1'b1, 15'h0013, 32'h0, 1'b1, 32'hAABBCCDD);
    idle(3);
    // Halfword extension
    wrt(15'h0006, 2'd0, 32'h00000080);
    wrt(15'h0007, 2'd0, 32'h000000FE);
    op(1'b1, 1'b0, 2'd1, 1'b1, 15'h0006, 32'h0, 1'b1, 32'hFFFFFE80);
    op(1'b1, 1'b0, 2'd1, 1'b0, 15'h0006, 32'h0, 1'b1, 32'h0000FE80);
    rd(15'h0010, 2'd3, 1'b1);
    idle(3);
    // Top-of-memory wrap
    wrt(15'h7FFF, 2'd2, 32'h01020304);
    op(1'b1, 1'b0, 2'd2, 1'b0, 15'h7FFF, 32'h0, 1'b1, 32'h01020304);
    rd(15'h0000, 2'd2, 1'b0);
    idle(3);
    // Back-to-back reads, then reads interleaved with writes
    rd(15'h0010, 2'd2, 1'b0);
    rd(15'h0013, 2'd0, 1'b1);
    rd(15'h0006, 2'd1, 1'b1);
    rd(15'h7FFF, 2'd1, 1'b0);
    rd(15'h0000, 2'd0, 1'b1);
    rd(15'h0011, 2'd1, 1'b1);
    wrt(15'h0020, 2'd2, 32'h8899AABB);
    rd(15'h0020, 2'd2, 1'b0);
    wrt(15'h0022, 2'd1, 32'h0000F00D);
    rd(15'h0021, 2'd2, 1'b0);
    idle(4);

    // Reset one cycle after a read request discards it
    rd(15'h0010, 2'd2, 1'b0);
    rst_i = 1'b0;
    req_i = 1'b1; wr_i = 1'b1; width_i = 2'd2; addr_i = 15'h0010; data_i = 32'h55555555;
    #1;
    q.delete();
    last_rd = 32'h0;
    chk("mid reset rd_vld", rd_vld_o, 0);
    chk("mid reset rd_o", rd_o, 0);
    chk("mid reset lane wr", {lw[3], lw[2], lw[1], lw[0]}, 0);
    repeat (2) begin
      @(posedge clk); cyc++; @(negedge clk);
      chk("in reset lane wr", {lw[3], lw[2], lw[1], lw[0]}, 0);
      chk("in reset rd_vld", rd_vld_o, 0);
    end
    req_i = 1'b0; wr_i = 1'b0;
    rst_i = 1'b1;
    idle(6);
    rd(15'h0010, 2'd2, 1'b0);
    idle(3);

    // Randomized mix
    for (int t = 0; t < 300; t++) begin
      logic [BA_W-1:0] a;
      int sel;
      a = ($urandom_range(0, 7) == 0) ? BA_W'(15'h7FC0 + $urandom_range(0, 63))
                                      : BA_W'($urandom_range(0, 63));
      sel = $urandom_range(0, 9);
      if (sel < 4) wrt(a, 2'($urandom_range(0, 3)), $urandom);
      else if (sel < 9) rd(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else idle(1);
    end
    idle(LAT + 3);
    chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
